dcache_data_array: RTL
======================

// Module: dcache_data_array
// PURPOSE
//  N-way set-associative D-cache data store with per-byte store writes and a multi-beat L2 line-fill engine.
//  Sits between the D-cache controller (tag compare, way select) and the L2 refill path.
//  Stores that hit the line currently being filled are merged into the incoming beats, so no written byte is lost.
//  Read data is registered, one cycle after rd_en.
// PARAMETERS
//  WAYS      2    number of ways (>=1)
//  SETS      256  lines per way; INDEX_W = clog2(SETS)
//  WORDS     4    words per line, = fill beats per line; OFF_W = clog2(WORDS)
//  WORD_W    32   word width, multiple of 8; BE_W = WORD_W/8
//  WAY_W     =max(1,clog2(WAYS)), derived
// PORTS
//  clk             in   1                     clock
//  reset           in   1                     asynchronous, active-low reset
//  rd_en           in   1                     read all ways at rd_index
//  rd_index        in   INDEX_W               read set
//  rd_valid        out  1                     rd_data holds the line for the previous rd_en
//  rd_data         out  WAYS*WORDS*WORD_W     way w, word k at [(w*WORDS+k)*WORD_W +: WORD_W]
//  st_en           in   1                     store request, taken when st_en & st_ready
//  st_ready        out  1                     store can be taken this cycle
//  st_way          in   WAY_W                 target way
//  st_index        in   INDEX_W               target set
//  st_offset       in   OFF_W                 target word
//  st_be           in   BE_W                  byte enables; byte b = bits [8b+7:8b]
//  st_data         in   WORD_W                store data
//  fill_start      in   1                     start refill of (fill_way, fill_index)
//  fill_way        in   WAY_W                 way to refill
//  fill_index      in   INDEX_W               set to refill
//  fill_beat_valid in   1                     one word from L2, delivered in order word0..word(WORDS-1)
//  fill_beat_data  in   WORD_W                beat data
//  fill_busy       out  1                     fill engine in state FILL
//  fill_done       out  1                     one-cycle pulse after the last beat is written
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, beat_cnt=0, merge_mask=0, rd_valid=0, rd_data=0, fill_busy=0, fill_done=0.
//    Array contents are not reset.
//  FSM IDLE: fill_start -> capture way/index, beat_cnt=0, merge_mask=0 -> FILL.
//    fill_beat_valid is ignored in IDLE.
//  FSM FILL: fill_busy=1; fill_start ignored; each fill_beat_valid writes word beat_cnt and does beat_cnt++.
//    The beat with beat_cnt==WORDS-1 -> DONE.
//  FSM DONE: fill_done=1 for one cycle; a beat in DONE is ignored -> IDLE.
//    fill_start in DONE is ignored; it is accepted the next cycle, in IDLE.
//  Reset mid-fill: returns to IDLE; the partially filled line is undefined and the controller keeps its tag invalid.
//  Read: rd_en at cycle t -> rd_data/rd_valid valid at t+1. rd_data holds its value while rd_en=0; rd_valid=0 then.
//    Read-before-write: a same-cycle store or beat to the read set returns the old data.
//    Reading the line being filled returns stale data for words not yet delivered.
//  st_ready = !(fill_busy & fill_beat_valid); a fill beat wins the single write port.
//  Accepted store: for each byte b with st_be[b]=1, the array byte is replaced by st_data byte b; other bytes keep their value.
//  Store to the line being filled (same way/index, state FILL), offset < beat_cnt: written to the array directly.
//  Store to the line being filled, offset >= beat_cnt: written to the array AND held in a per-word merge buffer.
//    merge_be[offset] |= st_be; the enabled bytes of merge_data[offset] are updated.
//    When that word's beat arrives, the written word = (beat & ~mask) | (merge_data & mask), mask expanded from merge_be.
//  Stores to any other line are unaffected by an active fill.
//  Merge buffer and merge_be are cleared on fill_start.
//  st_be=0 is accepted and writes nothing.
//  beat_cnt is OFF_W+1 bits wide and never wraps within a fill.
// TESTING
//  1. Reset, then fill way1 set 0x05 with beats 0xA0..0xA3, rd_en set 0x05
//     -> fill_done once, 1 cycle after the 4th beat; way1 words = A0,A1,A2,A3.
//  2. Line = 0x11223344; store offset 2, st_be=0b0101, data 0xAABBCCDD, then read
//     -> word2 = 0x11BB33DD; way0 of the same set unchanged.
//  3. Fill way0 set 3; after beat 0, store offset 3 be=0b1000 data 0xFF000000; beat 3 = 0x12345678
//     -> word3 = 0xFF345678.
//  4. Store with fill_beat_valid=1 in FILL -> st_ready=0, no array write; store completes the next cycle with st_ready=1.
//  5. Assert reset after 2 of 4 beats -> fill_busy=0 next edge, no fill_done.
//     A new fill of the same line completes normally with fresh data.
//  6. rd_en and a store to the same set/word in one cycle -> rd_data shows the old word; the next read shows the new word.

Source files
------------

// File: rtl/dcache_data_array.sv
// Set-associative D-cache data store: one byte-enabled write port shared by
// stores and L2 refill beats, registered all-ways read, and a store-merge buffer.
module dcache_data_array #(
  parameter int WAYS   = 2,
  parameter int SETS   = 256,
  parameter int WORDS  = 4,
  parameter int WORD_W = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rd_en,
  input  logic [$clog2(SETS)-1:0]       rd_index,
  output logic                          rd_valid,
  output logic [WAYS*WORDS*WORD_W-1:0]  rd_data,
  input  logic                          st_en,
  output logic                          st_ready,
  input  logic [((WAYS>1)?$clog2(WAYS):1)-1:0] st_way,
  input  logic [$clog2(SETS)-1:0]       st_index,
  input  logic [$clog2(WORDS)-1:0]      st_offset,
  input  logic [WORD_W/8-1:0]           st_be,
  input  logic [WORD_W-1:0]             st_data,
  input  logic                          fill_start,
  input  logic [((WAYS>1)?$clog2(WAYS):1)-1:0] fill_way,
  input  logic [$clog2(SETS)-1:0]       fill_index,
  input  logic                          fill_beat_valid,
  input  logic [WORD_W-1:0]             fill_beat_data,
  output logic                          fill_busy,
  output logic                          fill_done
);
  localparam int INDEX_W = $clog2(SETS);
  localparam int OFF_W   = $clog2(WORDS);
  localparam int BE_W    = WORD_W / 8;
  localparam int WAY_W   = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t                         state_q, state_d;
  logic [OFF_W:0]                 beat_cnt_q, beat_cnt_d;
  logic [WAY_W-1:0]               fill_way_q, fill_way_d;
  logic [INDEX_W-1:0]             fill_index_q, fill_index_d;
  logic [WORDS-1:0][BE_W-1:0]     merge_be_q, merge_be_d;
  logic [WORDS-1:0][WORD_W-1:0]   merge_data_q, merge_data_d;
  logic                           fill_busy_q, fill_busy_d;
  logic                           fill_done_q, fill_done_d;
  logic                           rd_valid_q;

  logic                           beat_take, st_take, st_hit_fill;
  logic [OFF_W-1:0]               beat_off;
  logic [WORD_W-1:0]              merge_mask;
  logic                           wr_en;
  logic [WAY_W-1:0]               wr_way;
  logic [INDEX_W-1:0]             wr_index;
  logic [OFF_W-1:0]               wr_off;
  logic [BE_W-1:0]                wr_be;
  logic [WORD_W-1:0]              wr_data;

  assign fill_busy = fill_busy_q;
  assign fill_done = fill_done_q;
  assign rd_valid  = rd_valid_q;

  assign beat_take   = (state_q == FILL) && fill_beat_valid;
  assign st_ready    = !(fill_busy_q && fill_beat_valid);
  assign st_take     = st_en && st_ready;
  assign beat_off    = beat_cnt_q[OFF_W-1:0];
  // Stores to a word not yet delivered must survive the later beat overwrite.
  assign st_hit_fill = (state_q == FILL) && (st_way == fill_way_q) &&
                       (st_index == fill_index_q) && ({1'b0, st_offset} >= beat_cnt_q);

  always_comb begin
    state_d      = state_q;
    beat_cnt_d   = beat_cnt_q;
    fill_way_d   = fill_way_q;
    fill_index_d = fill_index_q;
    merge_be_d   = merge_be_q;
    merge_data_d = merge_data_q;
    case (state_q)
      IDLE: begin
        if (fill_start) begin
          state_d      = FILL;
          fill_way_d   = fill_way;
          fill_index_d = fill_index;
          beat_cnt_d   = '0;
          merge_be_d   = '0;
          merge_data_d = '0;
        end
      end
      FILL: begin
        if (fill_beat_valid) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (beat_cnt_q == (OFF_W+1)'(WORDS-1)) state_d = DONE;
        end
        if (st_take && st_hit_fill) begin
          merge_be_d[st_offset] = merge_be_q[st_offset] | st_be;
          for (int b = 0; b < BE_W; b++)
            if (st_be[b]) merge_data_d[st_offset][8*b +: 8] = st_data[8*b +: 8];
        end
      end
      default: state_d = IDLE;
    endcase
    fill_busy_d = (state_d == FILL);
    fill_done_d = (state_d == DONE);
  end

  always_comb begin
    merge_mask = '0;
    for (int b = 0; b < BE_W; b++)
      merge_mask[8*b +: 8] = {8{merge_be_q[beat_off][b]}};
    wr_en    = 1'b0;
    wr_way   = st_way;
    wr_index = st_index;
    wr_off   = st_offset;
    wr_be    = st_be;
    wr_data  = st_data;
    if (beat_take) begin
      wr_en    = 1'b1;
      wr_way   = fill_way_q;
      wr_index = fill_index_q;
      wr_off   = beat_off;
      wr_be    = '1;
      wr_data  = (fill_beat_data & ~merge_mask) | (merge_data_q[beat_off] & merge_mask);
    end else if (st_take) begin
      wr_en = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      beat_cnt_q   <= '0;
      fill_way_q   <= '0;
      fill_index_q <= '0;
      merge_be_q   <= '0;
      merge_data_q <= '0;
      fill_busy_q  <= 1'b0;
      fill_done_q  <= 1'b0;
      rd_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_cnt_q   <= beat_cnt_d;
      fill_way_q   <= fill_way_d;
      fill_index_q <= fill_index_d;
      merge_be_q   <= merge_be_d;
      merge_data_q <= merge_data_d;
      fill_busy_q  <= fill_busy_d;
      fill_done_q  <= fill_done_d;
      rd_valid_q   <= rd_en;
    end
  end

  // One RAM per (way, word) so a whole set of every way is read in one cycle.
  for (genvar gi = 0; gi < WAYS*WORDS; gi++) begin : g_bank
    logic [WORD_W-1:0] mem [SETS];
    logic [WORD_W-1:0] rd_word_q;
    logic              wr_sel;

    assign wr_sel = wr_en && (wr_way == WAY_W'(gi / WORDS)) && (wr_off == OFF_W'(gi % WORDS));

    always_ff @(posedge clk) begin
      if (wr_sel)
        for (int b = 0; b < BE_W; b++)
          if (wr_be[b]) mem[wr_index][8*b +: 8] <= wr_data[8*b +: 8];
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset)     rd_word_q <= '0;
      else if (rd_en) rd_word_q <= mem[rd_index];
    end

    assign rd_data[gi*WORD_W +: WORD_W] = rd_word_q;
  end

endmodule
